// File: rtl/bypass_unlock_ctrl.sv
// Bypass-mode gatekeeper: opens bypass for WINDOW cycles after the 4-nibble KEY arrives in order,
// and locks out for LOCKOUT cycles after MAX_FAIL consecutive wrong sequences.
module bypass_unlock_ctrl #(
   parameter logic [15:0] KEY      = 16'hA5C3,
   parameter int          WINDOW   = 256,
   parameter int          GAP      = 16,
   parameter int          MAX_FAIL = 3,
   parameter int          LOCKOUT  = 1024,
   localparam int         FW       = $clog2(MAX_FAIL + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   input  logic [3:0]    cmd,
   input  logic          lock_req,
   output logic          bypass_en,
   output logic          unlock_ok,
   output logic          locked_out,
   output logic [FW-1:0] fail_cnt,
   output logic [1:0]    state
);

   localparam int TMAX = (WINDOW > GAP) ? ((WINDOW > LOCKOUT) ? WINDOW : LOCKOUT)
                                        : ((GAP > LOCKOUT) ? GAP : LOCKOUT);
   // One extra count of headroom so the gap reload value GAP itself always fits.
   localparam int TW   = $clog2(TMAX + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEQ    = 2'd1,
      ST_ACTIVE = 2'd2,
      ST_LOCK   = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      idx_q, idx_d;
   logic [TW-1:0]   tmr_q, tmr_d;
   logic [FW-1:0]   fail_q, fail_d;
   logic            unlock_q, unlock_d;
   logic            bypass_q, locked_q;
   logic [3:0]      key_nib;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      tmr_d    = tmr_q;
      fail_d   = fail_q;
      unlock_d = 1'b0;
      key_nib  = 4'(KEY >> (5'd12 - {1'b0, idx_q, 2'b00}));
      case (state_q)
         ST_IDLE, ST_SEQ: begin
            if (cmd_valid) begin
               if (cmd == key_nib) begin
                  if (idx_q == 2'd3) begin
                     state_d  = ST_ACTIVE;
                     tmr_d    = TW'(WINDOW - 1);
                     idx_d    = 2'd0;
                     fail_d   = '0;
                     unlock_d = 1'b1;
                  end else begin
                     state_d = ST_SEQ;
                     idx_d   = idx_q + 2'd1;
                     tmr_d   = TW'(GAP);
                  end
               end else begin
                  state_d = ST_IDLE;
                  idx_d   = 2'd0;
                  if (fail_q == FW'(MAX_FAIL - 1)) begin
                     state_d = ST_LOCK;
                     tmr_d   = TW'(LOCKOUT - 1);
                     fail_d  = FW'(MAX_FAIL);
                  end else begin
                     fail_d = fail_q + FW'(1);
                  end
               end
            end else if (state_q == ST_SEQ) begin
               // Gap expiry is a silent abort: fail count is left alone.
               if (tmr_q <= TW'(1)) begin
                  state_d = ST_IDLE;
                  idx_d   = 2'd0;
                  tmr_d   = '0;
               end else begin
                  tmr_d = tmr_q - TW'(1);
               end
            end
         end
         ST_ACTIVE: begin
            if (lock_req || (tmr_q == '0)) begin
               state_d = ST_IDLE;
               tmr_d   = '0;
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         ST_LOCK: begin
            if (tmr_q == '0) begin
               state_d = ST_IDLE;
               fail_d  = '0;
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         idx_q    <= 2'd0;
         tmr_q    <= '0;
         fail_q   <= '0;
         unlock_q <= 1'b0;
         bypass_q <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         tmr_q    <= tmr_d;
         fail_q   <= fail_d;
         unlock_q <= unlock_d;
         bypass_q <= (state_d == ST_ACTIVE);
         locked_q <= (state_d == ST_LOCK);
      end
   end

   assign bypass_en  = bypass_q;
   assign unlock_ok  = unlock_q;
   assign locked_out = locked_q;
   assign fail_cnt   = fail_q;
   assign state      = state_q;

endmodule
